// File: rtl/cq_axis_pkg.sv
// Shared constants and field builders for the CQ request generator.
package cq_axis_pkg;

  localparam logic [3:0]  REQ_MEM_RD   = 4'h0;
  localparam logic [3:0]  REQ_MEM_WR   = 4'h1;
  localparam logic [15:0] REQUESTER_ID = 16'h10EE;
  localparam int unsigned CQ_TUSER_W   = 85;

  // FSM encoding kept as plain constants for older tool flows.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Upper 64 bits of the 128-bit CQ header.
  function automatic logic [63:0] cq_descriptor(input logic [2:0]  bar,
                                                input logic [7:0]  tag,
                                                input logic [3:0]  req_type,
                                                input logic [10:0] dw_count);
    return {1'b0, 3'h0, 3'h0, 6'd0, bar, 8'h00, tag, REQUESTER_ID, 1'b0, req_type, dw_count};
  endfunction

  // sop lands on bit 40; the zero pad fills the remainder of the 85-bit bus.
  function automatic logic [CQ_TUSER_W-1:0] cq_tuser(input logic       sop,
                                                     input logic [3:0] first_be,
                                                     input logic [3:0] last_be);
    return {44'd0, sop, 32'd0, last_be, first_be};
  endfunction

endpackage

// File: rtl/cq_lfsr_throttle.sv
// Free-running Galois LFSR that requests an idle bubble with a fixed probability.
module cq_lfsr_throttle #(
  parameter int unsigned THROTTLE_PCT = 0,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2345
) (
  input  logic user_clk,
  input  logic user_reset,
  output logic stall_req
);

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic [31:0] lfsr_q, lfsr_d;
  logic [15:0] pct_roll;

  // Next LFSR state: shift right, fold taps in when the output bit is set.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'd0);
  end

  // LFSR advances every cycle regardless of traffic.
  always_ff @(posedge user_clk) begin
    if (user_reset) lfsr_q <= LFSR_SEED;
    else            lfsr_q <= lfsr_d;
  end

  // Percentage compare on the low half of the LFSR.
  always_comb begin
    pct_roll  = lfsr_q[15:0] % 16'd100;
    stall_req = (THROTTLE_PCT != 0) && (32'(pct_roll) < THROTTLE_PCT);
  end

endmodule

// File: rtl/cq_axis_req_gen.sv
// Command-driven PCIe CQ AXI-Stream TLP generator (64/128/256-bit).
module cq_axis_req_gen
  import cq_axis_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter int unsigned MAX_DW       = 8,
  parameter int unsigned THROTTLE_PCT = 0,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2345
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_op,
  input  logic [63:0]             cmd_addr,
  input  logic [2:0]              cmd_bar,
  input  logic [10:0]             cmd_dw_count,
  input  logic [3:0]              cmd_first_be,
  input  logic [3:0]              cmd_last_be,
  input  logic [32*MAX_DW-1:0]    cmd_data,
  output logic [C_DATA_WIDTH-1:0] m_axis_cq_tdata,
  output logic [CQ_TUSER_W-1:0]   m_axis_cq_tuser,
  output logic                    m_axis_cq_tlast,
  output logic                    m_axis_cq_tvalid,
  output logic [KEEP_WIDTH-1:0]   m_axis_cq_tkeep,
  input  logic [21:0]             m_axis_cq_tready,
  output logic                    cmd_err,
  output logic                    busy
);

  localparam int unsigned DPB       = C_DATA_WIDTH / 32;
  localparam int unsigned STREAM_DW = 4 + MAX_DW;
  localparam int unsigned MAX_BEATS = (STREAM_DW + DPB - 1) / DPB;
  localparam int unsigned PAD_DW    = MAX_BEATS * DPB;
  localparam int unsigned BEAT_W    = $clog2(MAX_BEATS + 1);

  logic [0:0]             state_q, state_d;
  logic [PAD_DW*32-1:0]   stream_q, stream_d, new_stream;
  logic [BEAT_W-1:0]      beat_q, beat_d, last_beat_q, last_beat_d;
  logic [KEEP_WIDTH-1:0]  last_keep_q, last_keep_d, new_keep;
  logic [3:0]             first_be_q, first_be_d, last_be_q, last_be_d;
  logic [7:0]             tag_q, tag_d;
  logic                   valid_q, valid_d;
  logic                   cmd_err_q, cmd_err_d;

  logic                   stall_req, in_send, is_last, cmd_fire, cmd_legal;
  logic [10:0]            total_dw, rem_dw, last_cnt;
  logic                   unused_tready;

  assign unused_tready = ^m_axis_cq_tready[21:1];

  cq_lfsr_throttle #(
    .THROTTLE_PCT(THROTTLE_PCT),
    .LFSR_SEED   (LFSR_SEED)
  ) u_throttle (
    .user_clk  (user_clk),
    .user_reset(user_reset),
    .stall_req (stall_req)
  );

  // Stream image, beat count and last-beat keep for the command on the inputs.
  always_comb begin
    cmd_legal = (cmd_dw_count != 11'd0) && (cmd_dw_count <= 11'(MAX_DW)) &&
                (cmd_op || (cmd_dw_count == 11'd1));
    total_dw  = 11'd4 + (cmd_op ? cmd_dw_count : 11'd0);
    rem_dw    = total_dw % 11'(DPB);
    last_cnt  = (rem_dw == 11'd0) ? 11'(DPB) : rem_dw;
    for (int j = 0; j < KEEP_WIDTH; j++) new_keep[j] = (11'(j) < last_cnt);
    new_stream          = '0;
    new_stream[63:0]    = cmd_addr;
    new_stream[127:64]  = cq_descriptor(cmd_bar, tag_q, cmd_op ? REQ_MEM_WR : REQ_MEM_RD,
                                        cmd_dw_count);
    // Payload beyond dw_count stays zero so partial beats need no masking later.
    for (int i = 0; i < MAX_DW; i++) begin
      if (cmd_op && (11'(i) < cmd_dw_count)) new_stream[128+32*i +: 32] = cmd_data[32*i +: 32];
    end
  end

  // Handshake and output view of the current beat.
  always_comb begin
    in_send          = (state_q == ST_SEND);
    is_last          = (beat_q == last_beat_q);
    cmd_ready        = !in_send && !user_reset;
    cmd_fire         = cmd_valid && cmd_ready;
    busy             = in_send;
    cmd_err          = cmd_err_q;
    m_axis_cq_tvalid = valid_q;
    m_axis_cq_tdata  = in_send ? stream_q[beat_q*C_DATA_WIDTH +: C_DATA_WIDTH] : '0;
    m_axis_cq_tlast  = in_send && is_last;
    m_axis_cq_tkeep  = !in_send ? '0 : (is_last ? last_keep_q : '1);
    m_axis_cq_tuser  = in_send ? cq_tuser(beat_q == '0, first_be_q, last_be_q) : '0;
  end

  // FSM: latch a legal command, then walk beats with optional bubbles between them.
  always_comb begin
    state_d     = state_q;
    stream_d    = stream_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    last_keep_d = last_keep_q;
    first_be_d  = first_be_q;
    last_be_d   = last_be_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    cmd_err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_legal) begin
            state_d     = ST_SEND;
            stream_d    = new_stream;
            beat_d      = '0;
            last_beat_d = BEAT_W'((total_dw + 11'(DPB - 1)) / 11'(DPB) - 11'd1);
            last_keep_d = new_keep;
            first_be_d  = cmd_first_be;
            last_be_d   = (cmd_dw_count == 11'd1) ? 4'h0 : cmd_last_be;
            valid_d     = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (valid_q) begin
          if (m_axis_cq_tready[0]) begin
            if (is_last) begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
              tag_d   = tag_q + 8'd1;
            end else begin
              beat_d  = beat_q + BEAT_W'(1);
              valid_d = !stall_req;
            end
          end
        end else begin
          // Bubble: retry the throttle roll every cycle.
          valid_d = !stall_req;
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q     <= ST_IDLE;
      stream_q    <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      last_keep_q <= '0;
      first_be_q  <= '0;
      last_be_q   <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stream_q    <= stream_d;
      beat_q      <= beat_d;
      last_beat_q <= last_beat_d;
      last_keep_q <= last_keep_d;
      first_be_q  <= first_be_d;
      last_be_q   <= last_be_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

endmodule
